sram_burst_master: RTL and testbench
====================================

SRAM_BURST_MASTER -- requirements
Module: sram_burst_master

Interface
REQ-001 Parameter aw, default 12, SRAM address width.
REQ-002 Parameter dw, default 16, SRAM data width.
REQ-003 Parameter lw, default 8, burst length field width; maximum burst 2^lw words.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-008 cmd_wr  in  1  1 = write burst, 0 = read burst.
REQ-009 cmd_addr  in  aw  burst start address.
REQ-010 cmd_len  in  lw  burst length minus one (0 = one word).
REQ-011 wr_data  in  dw  write stream data.
REQ-012 wr_valid  in  1  write stream word offered.
REQ-013 wr_ready  out  1  write stream word accepted.
REQ-014 rd_data  out  dw  read stream data.
REQ-015 rd_valid  out  1  read stream word present.
REQ-016 rd_ready  in  1  read stream consumer accepts word.
REQ-017 done  out  1  one-cycle pulse at burst completion.
REQ-018 ao_ce, ao_we, ao_oe  out  1 each  SRAM chip enable, write enable, output enable.
REQ-019 ao_addr_w  out  aw  SRAM write address; ao_addr_r  out  aw  SRAM read address.
REQ-020 ao_data  out  dw  SRAM write data.
REQ-021 ai_data  in  dw  SRAM read data; ai_valid  in  1  SRAM read data valid for current ao_addr_r.

Function
REQ-022 States IDLE, WR, RD, DRAIN, DONE; all SRAM-side outputs are registered.
REQ-023 IDLE: cmd_ready=1; on cmd_valid, latch addr/len/wr, clear word counter, go WR (cmd_wr=1) or RD (cmd_wr=0).
REQ-024 cmd_ready=0 in every state except IDLE; cmd_valid outside IDLE is ignored.
REQ-025 WR: wr_ready=1; each wr_valid&wr_ready cycle drives, next cycle, ao_ce=1, ao_we=1, ao_oe=0, ao_addr_w=current addr, ao_data=wr_data; otherwise ao_ce=0, ao_we=0.
REQ-026 WR: after accepting word count==len, go DONE; wr_ready=0 from that next cycle.
REQ-027 RD: ao_ce=1, ao_oe=1, ao_we=0, ao_addr_r=current addr held stable until a word is captured.
REQ-028 RD capture: when ai_valid=1 and (rd_valid=0 or rd_ready=1), register ai_data into rd_data, set rd_valid, increment addr and counter; next address appears one cycle later.
REQ-029 RD: ai_valid while buffer full and rd_ready=0 is ignored; address held, SRAM re-presents same word, no word lost or duplicated.
REQ-030 rd_valid clears on rd_ready unless a new capture occurs the same cycle; rd_data stable while rd_valid=1 and rd_ready=0.
REQ-031 After capturing last word go DRAIN: ao_ce=0, ao_oe=0; leave DRAIN to DONE when last word taken (rd_valid&rd_ready).
REQ-032 DONE: done=1 for exactly one cycle, all SRAM enables 0, then IDLE.
REQ-033 Address increment modulo 2^aw (aw'h...FFF wraps to 0); counter width lw, compare against len.
REQ-034 ai_valid and ai_data ignored in IDLE, WR, DRAIN, DONE.

Reset
REQ-035 rst low immediately forces state IDLE and outputs: cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, done=0, ao_ce=0, ao_we=0, ao_oe=0, ao_addr_w=0, ao_addr_r=0, ao_data=0.
REQ-036 Reset mid-burst aborts the burst with no done pulse; first command accepted on first rising edge with rst high.

Verification
REQ-037 Write cmd addr=3 len=1, wr_data 7 then 9 back-to-back -> ao_we pulses two cycles, ao_addr_w 3,4, ao_data 7,9, done one cycle after last write.
REQ-038 Read cmd addr=3 len=1, SRAM model with 2 wait cycles, rd_ready=1 -> ao_addr_r held 3 until ai_valid, rd_data 7 then 9, done after second word taken.
REQ-039 Read with rd_ready=0 for 5 cycles after first capture -> rd_data=7 stable, ao_addr_r=4 held, second word 9 delivered once after release.
REQ-040 Write cmd addr=4095 len=1 -> ao_addr_w 4095 then 0.
REQ-041 rst low after first read word -> all outputs at reset values same cycle, no done; new cmd accepted after release.
REQ-042 cmd_valid held high during a burst -> cmd_ready=0, second command accepted only in IDLE after done.

Source files
------------

// File: rtl/sram_burst_master.sv
// Burst master for a simple synchronous SRAM: accepts one write or read burst command,
// streams write words out to the SRAM or SRAM words into a one-deep read buffer, and
// pulses done when the burst is complete.
module sram_burst_master #(
  parameter int unsigned aw = 12,
  parameter int unsigned dw = 16,
  parameter int unsigned lw = 8
) (
  input  logic          clk,
  input  logic          rst,
  // command channel
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [aw-1:0] cmd_addr,
  input  logic [lw-1:0] cmd_len,
  // write stream
  input  logic [dw-1:0] wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  // read stream
  output logic [dw-1:0] rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          done,
  // SRAM side
  output logic          ao_ce,
  output logic          ao_we,
  output logic          ao_oe,
  output logic [aw-1:0] ao_addr_w,
  output logic [aw-1:0] ao_addr_r,
  output logic [dw-1:0] ao_data,
  input  logic [dw-1:0] ai_data,
  input  logic          ai_valid
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWr    = 3'd1,
    StRd    = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e        r_state, w_state_d;
  logic [aw-1:0] r_addr, w_addr_d;
  logic [lw-1:0] r_cnt, w_cnt_d;
  logic [lw-1:0] r_len, w_len_d;
  logic          r_rd_valid, w_rd_valid_d;
  logic [dw-1:0] r_rd_data, w_rd_data_d;
  logic          r_ce, w_ce_d;
  logic          r_we, w_we_d;
  logic          r_oe, w_oe_d;
  logic [aw-1:0] r_addr_w, w_addr_w_d;
  logic [aw-1:0] r_addr_r, w_addr_r_d;
  logic [dw-1:0] r_data, w_data_d;
  logic          w_last;

  assign w_last = (r_cnt == r_len);

  // Next-state, datapath and registered-output decode for the burst sequencer.
  always_comb begin
    w_state_d    = r_state;
    w_addr_d     = r_addr;
    w_cnt_d      = r_cnt;
    w_len_d      = r_len;
    w_rd_valid_d = r_rd_valid;
    w_rd_data_d  = r_rd_data;
    w_ce_d       = 1'b0;
    w_we_d       = 1'b0;
    w_oe_d       = 1'b0;
    w_addr_w_d   = r_addr_w;
    w_addr_r_d   = r_addr_r;
    w_data_d     = r_data;

    unique case (r_state)
      StIdle: begin
        if (cmd_valid) begin
          w_addr_d = cmd_addr;
          w_len_d  = cmd_len;
          w_cnt_d  = '0;
          if (cmd_wr) begin
            w_state_d = StWr;
          end else begin
            // Start presenting the first read address right away.
            w_state_d  = StRd;
            w_ce_d     = 1'b1;
            w_oe_d     = 1'b1;
            w_addr_r_d = cmd_addr;
          end
        end
      end

      StWr: begin
        if (wr_valid) begin
          w_ce_d     = 1'b1;
          w_we_d     = 1'b1;
          w_addr_w_d = r_addr;
          w_data_d   = wr_data;
          w_addr_d   = r_addr + 1'b1;
          w_cnt_d    = r_cnt + 1'b1;
          if (w_last) begin
            w_state_d = StDone;
          end
        end
      end

      StRd: begin
        if (rd_ready) begin
          w_rd_valid_d = 1'b0;
        end
        // A full buffer that is not being drained blocks capture; the address is held
        // so the SRAM keeps re-presenting the same word.
        if (ai_valid && (!r_rd_valid || rd_ready)) begin
          w_rd_data_d  = ai_data;
          w_rd_valid_d = 1'b1;
          w_addr_d     = r_addr + 1'b1;
          w_cnt_d      = r_cnt + 1'b1;
          if (w_last) begin
            w_state_d = StDrain;
          end
        end
        if (w_state_d == StRd) begin
          w_ce_d     = 1'b1;
          w_oe_d     = 1'b1;
          w_addr_r_d = w_addr_d;
        end
      end

      StDrain: begin
        if (r_rd_valid && rd_ready) begin
          w_rd_valid_d = 1'b0;
          w_state_d    = StDone;
        end
      end

      StDone: begin
        w_state_d = StIdle;
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_ce       <= 1'b0;
      r_we       <= 1'b0;
      r_oe       <= 1'b0;
      r_addr_w   <= '0;
      r_addr_r   <= '0;
      r_data     <= '0;
    end else begin
      r_state    <= w_state_d;
      r_addr     <= w_addr_d;
      r_cnt      <= w_cnt_d;
      r_len      <= w_len_d;
      r_rd_valid <= w_rd_valid_d;
      r_rd_data  <= w_rd_data_d;
      r_ce       <= w_ce_d;
      r_we       <= w_we_d;
      r_oe       <= w_oe_d;
      r_addr_w   <= w_addr_w_d;
      r_addr_r   <= w_addr_r_d;
      r_data     <= w_data_d;
    end
  end

  assign cmd_ready = (r_state == StIdle);
  assign wr_ready  = (r_state == StWr);
  assign done      = (r_state == StDone);
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign ao_ce     = r_ce;
  assign ao_we     = r_we;
  assign ao_oe     = r_oe;
  assign ao_addr_w = r_addr_w;
  assign ao_addr_r = r_addr_r;
  assign ao_data   = r_data;

endmodule

// File: tb/tb_sram_burst_master.sv
// Self-checking bench for sram_burst_master: directed scenarios plus randomized
// write/read-back bursts against a word-level memory model.
module tb_sram_burst_master;
  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 16;
  localparam int unsigned LW  = 8;
  localparam int unsigned MEM = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          done;
  logic          ao_ce, ao_we, ao_oe;
  logic [AW-1:0] ao_addr_w, ao_addr_r;
  logic [DW-1:0] ao_data;
  logic [DW-1:0] ai_data;
  logic          ai_valid;

  always #5 clk = ~clk;

  sram_burst_master #(.aw(AW), .dw(DW), .lw(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .done      (done),
    .ao_ce     (ao_ce),
    .ao_we     (ao_we),
    .ao_oe     (ao_oe),
    .ao_addr_w (ao_addr_w),
    .ao_addr_r (ao_addr_r),
    .ao_data   (ao_data),
    .ai_data   (ai_data),
    .ai_valid  (ai_valid)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // SRAM model: data becomes valid once an address has been held for sram_wait cycles.
  logic [DW-1:0] sram [MEM];
  logic [AW-1:0] s_addr = '0;
  int            s_cnt = 0;
  int            sram_wait = 2;
  logic          ai_force = 1'b0;
  logic          sram_ok;

  assign sram_ok  = ao_ce && ao_oe && !ao_we && (s_cnt > 0) && (ao_addr_r == s_addr)
                    && (s_cnt >= sram_wait);
  assign ai_valid = sram_ok || ai_force;
  assign ai_data  = sram_ok ? sram[ao_addr_r] : 16'hBAD0;

  // Track how long the read address has been stable.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ao_ce && ao_oe && !ao_we) begin
      if (s_cnt > 0 && ao_addr_r == s_addr) s_cnt <= s_cnt + 1;
      else begin
        s_addr <= ao_addr_r;
        s_cnt  <= 1;
      end
    end else begin
      s_cnt <= 0;
    end
  end

  // Observed traffic, sampled mid-cycle.
  logic [AW-1:0] wq_addr[$];
  logic [DW-1:0] wq_data[$];
  int            wq_cyc[$];
  logic [DW-1:0] rq[$];
  int            rq_cyc[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            acc_cnt = 0;

  // Record SRAM writes, read handshakes, done pulses and command acceptances.
  always @(negedge clk) begin
    if (ao_ce && ao_we) begin
      wq_addr.push_back(ao_addr_w);
      wq_data.push_back(ao_data);
      wq_cyc.push_back(cyc);
      sram[ao_addr_w] <= ao_data;
    end
    if (rd_valid && rd_ready) begin
      rq.push_back(rd_data);
      rq_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
  end

  // Reference model state: what memory should contain after the bursts issued so far.
  logic [DW-1:0] ref_mem [MEM];
  logic [DW-1:0] wdat[$];
  int            acc_cyc[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); rq.delete(); rq_cyc.delete();
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l,
                       output bit to);
    to        = 1'b1;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_len   = l;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        tick();
        to = 1'b0;
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic stream_write(input int gap_pct, output bit to);
    int idx = 0;
    to = 1'b1;
    acc_cyc.delete();
    for (int c = 0; c < 3000; c++) begin
      if (idx < wdat.size()) begin
        wr_valid = ($urandom_range(99) >= gap_pct);
        wr_data  = wdat[idx];
      end else begin
        wr_valid = 1'b0;
      end
      @(negedge clk);
      if (wr_valid && wr_ready) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
      if (done) begin
        tick();
        to = 1'b0;
        break;
      end
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic stream_read(input int bp_pct, output bit to);
    to = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      rd_ready = ($urandom_range(99) >= bp_pct);
      @(negedge clk);
      if (done) begin
        tick();
        to = 1'b0;
        break;
      end
      tick();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    int d0;
    tick(); tick();
    rst = 1'b0;
    #1;
    tests++;
    if ({cmd_ready, wr_ready, rd_valid, done, ao_ce, ao_we, ao_oe} !== 7'b1000000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 1000000",
               {cmd_ready, wr_ready, rd_valid, done, ao_ce, ao_we, ao_oe});
    end
    tests++;
    if ({rd_data, ao_addr_w, ao_addr_r, ao_data} !== '0) begin
      fails++;
      $display("FAIL reset_data: rd_data=%h addr_w=%h addr_r=%h data=%h want all 0",
               rd_data, ao_addr_w, ao_addr_r, ao_data);
    end
    tick(); tick();
    // Release with a command already offered: it must be taken on the first edge.
    d0        = done_cnt;
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_addr  = 12'd0;
    cmd_len   = 8'd0;
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({wr_ready, cmd_ready} !== 2'b10) begin
      fails++;
      $display("FAIL reset_first_cmd: wr_ready,cmd_ready=%b want 10", {wr_ready, cmd_ready});
    end
    tick();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    tests++;
    if (done_cnt !== d0) begin
      fails++;
      $display("FAIL reset_abort_done: done pulses %0d want 0", done_cnt - d0);
    end
  endtask

  task automatic test_write_basic();
    bit to;
    int d0;
    clear_obs();
    d0   = done_cnt;
    wdat = '{16'd7, 16'd9};
    issue(1'b1, 12'd3, 8'd1, to);
    stream_write(0, to);
    tick(); tick();
    ref_mem[3] = 16'd7;
    ref_mem[4] = 16'd9;
    tests++;
    if (to !== 1'b0 || wq_addr.size() != 2 || acc_cyc.size() != 2) begin
      fails++;
      $display("FAIL wr_basic_count: timeout=%0b strobes=%0d accepts=%0d want 0/2/2",
               to, wq_addr.size(), acc_cyc.size());
    end else begin
      tests++;
      if (wq_addr[0] !== 12'd3 || wq_addr[1] !== 12'd4) begin
        fails++;
        $display("FAIL wr_basic_addr: got %0d,%0d want 3,4", wq_addr[0], wq_addr[1]);
      end
      tests++;
      if (wq_data[0] !== 16'd7 || wq_data[1] !== 16'd9) begin
        fails++;
        $display("FAIL wr_basic_data: got %0d,%0d want 7,9", wq_data[0], wq_data[1]);
      end
      tests++;
      if (wq_cyc[0] != acc_cyc[0] + 1 || wq_cyc[1] != wq_cyc[0] + 1) begin
        fails++;
        $display("FAIL wr_basic_timing: strobe cycles %0d,%0d accept %0d want %0d,%0d",
                 wq_cyc[0], wq_cyc[1], acc_cyc[0], acc_cyc[0] + 1, acc_cyc[0] + 2);
      end
      tests++;
      if (done_cyc != acc_cyc[1] + 1 || done_cnt - d0 != 1) begin
        fails++;
        $display("FAIL wr_basic_done: done at %0d count %0d want at %0d count 1",
                 done_cyc, done_cnt - d0, acc_cyc[1] + 1);
      end
    end
  endtask

  task automatic test_write_wrap();
    bit to;
    logic [DW-1:0] a0, a1;
    clear_obs();
    a0   = DW'($urandom);
    a1   = DW'($urandom);
    wdat = '{a0, a1};
    issue(1'b1, 12'd4095, 8'd1, to);
    stream_write(20, to);
    tick();
    ref_mem[4095] = a0;
    ref_mem[0]    = a1;
    tests++;
    if (to !== 1'b0 || wq_addr.size() != 2) begin
      fails++;
      $display("FAIL wr_wrap_count: timeout=%0b strobes=%0d want 0/2", to, wq_addr.size());
    end else begin
      tests++;
      if (wq_addr[0] !== 12'd4095 || wq_addr[1] !== 12'd0) begin
        fails++;
        $display("FAIL wr_wrap_addr: got %0d,%0d want 4095,0", wq_addr[0], wq_addr[1]);
      end
    end
  endtask

  task automatic test_read_basic();
    bit to, seen;
    int hold, bad_addr, d0;
    clear_obs();
    sram_wait = 2;
    d0        = done_cnt;
    hold      = 0;
    bad_addr  = 0;
    seen      = 1'b0;
    issue(1'b0, 12'd3, 8'd1, to);
    rd_ready = 1'b1;
    to       = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rd_valid) seen = 1'b1;
      if (!seen && ao_oe) begin
        hold++;
        if (ao_addr_r !== 12'd3) bad_addr++;
      end
      if (done) begin
        tick();
        to = 1'b0;
        break;
      end
      tick();
    end
    rd_ready = 1'b0;
    tick();
    tests++;
    if (hold != 3 || bad_addr != 0) begin
      fails++;
      $display("FAIL rd_basic_hold: addr cycles %0d (bad %0d) want 3 (bad 0)", hold, bad_addr);
    end
    tests++;
    if (to !== 1'b0 || rq.size() != 2) begin
      fails++;
      $display("FAIL rd_basic_count: timeout=%0b words=%0d want 0/2", to, rq.size());
    end else begin
      tests++;
      if (rq[0] !== ref_mem[3] || rq[1] !== ref_mem[4]) begin
        fails++;
        $display("FAIL rd_basic_data: got %0d,%0d want %0d,%0d", rq[0], rq[1], ref_mem[3],
                 ref_mem[4]);
      end
      tests++;
      if (done_cyc != rq_cyc[1] + 1 || done_cnt - d0 != 1) begin
        fails++;
        $display("FAIL rd_basic_done: done at %0d count %0d want at %0d count 1", done_cyc,
                 done_cnt - d0, rq_cyc[1] + 1);
      end
    end
  endtask

  task automatic test_read_backpressure();
    bit to, seen;
    clear_obs();
    sram_wait = 2;
    seen      = 1'b0;
    issue(1'b0, 12'd3, 8'd1, to);
    rd_ready = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rd_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    tests++;
    if (seen !== 1'b1) begin
      fails++;
      $display("FAIL rd_bp_first: no word within budget, got 0 want 1");
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      tests++;
      if (rd_valid !== 1'b1 || rd_data !== ref_mem[3] || ao_addr_r !== 12'd4) begin
        fails++;
        $display("FAIL rd_bp_hold%0d: valid=%b data=%0d addr_r=%0d want 1/%0d/4", i, rd_valid,
                 rd_data, ao_addr_r, ref_mem[3]);
      end
    end
    tick();
    stream_read(0, to);
    tick();
    tests++;
    if (to !== 1'b0 || rq.size() != 2) begin
      fails++;
      $display("FAIL rd_bp_count: timeout=%0b words=%0d want 0/2", to, rq.size());
    end else begin
      tests++;
      if (rq[0] !== ref_mem[3] || rq[1] !== ref_mem[4]) begin
        fails++;
        $display("FAIL rd_bp_data: got %0d,%0d want %0d,%0d", rq[0], rq[1], ref_mem[3],
                 ref_mem[4]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    bit to, seen;
    int d0;
    logic [DW-1:0] v;
    clear_obs();
    sram_wait = 1;
    seen      = 1'b0;
    d0        = done_cnt;
    issue(1'b0, 12'd3, 8'd1, to);
    rd_ready = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rd_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    #1;
    rst = 1'b0;
    #1;
    tests++;
    if (seen !== 1'b1 ||
        {cmd_ready, wr_ready, rd_valid, done, ao_ce, ao_we, ao_oe} !== 7'b1000000) begin
      fails++;
      $display("FAIL rst_mid_ctrl: seen=%b ctrl=%b want 1/1000000", seen,
               {cmd_ready, wr_ready, rd_valid, done, ao_ce, ao_we, ao_oe});
    end
    tests++;
    if ({rd_data, ao_addr_w, ao_addr_r, ao_data} !== '0) begin
      fails++;
      $display("FAIL rst_mid_data: rd_data=%h addr_w=%h addr_r=%h data=%h want all 0",
               rd_data, ao_addr_w, ao_addr_r, ao_data);
    end
    tick(); tick();
    rst = 1'b1;
    tests++;
    if (done_cnt !== d0) begin
      fails++;
      $display("FAIL rst_mid_done: done pulses %0d want 0", done_cnt - d0);
    end
    clear_obs();
    v    = DW'($urandom);
    wdat = '{v};
    issue(1'b1, 12'd10, 8'd0, to);
    stream_write(0, to);
    ref_mem[10] = v;
    tests++;
    if (to !== 1'b0 || wq_addr.size() != 1) begin
      fails++;
      $display("FAIL rst_mid_recover: timeout=%0b strobes=%0d want 0/1", to, wq_addr.size());
    end
  endtask

  task automatic test_cmd_hold();
    bit to1, to2;
    int a0, d0;
    logic [DW-1:0] w1[$];
    logic [DW-1:0] w2[$];
    logic [DW-1:0] exp_d;
    int bad = 0;
    clear_obs();
    a0 = acc_cnt;
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      w1.push_back(DW'($urandom));
      w2.push_back(DW'($urandom));
    end
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_addr  = 12'd20;
    cmd_len   = 8'd2;
    wdat      = w1;
    stream_write(10, to1);
    tick();
    cmd_valid = 1'b0;
    wdat      = w2;
    stream_write(10, to2);
    tick(); tick();
    for (int i = 0; i < 3; i++) ref_mem[20 + i] = w2[i];
    tests++;
    if (to1 !== 1'b0 || to2 !== 1'b0 || acc_cnt - a0 != 2 || done_cnt - d0 != 2) begin
      fails++;
      $display("FAIL hold_accepts: timeouts=%b%b accepts=%0d dones=%0d want 00/2/2", to1, to2,
               acc_cnt - a0, done_cnt - d0);
    end
    tests++;
    if (wq_addr.size() != 6) begin
      fails++;
      $display("FAIL hold_strobes: got %0d want 6", wq_addr.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        exp_d = (i < 3) ? w1[i] : w2[i - 3];
        if (wq_addr[i] !== AW'(20 + (i % 3)) || wq_data[i] !== exp_d) bad++;
      end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL hold_seq: %0d strobes wrong want 0", bad);
      end
    end
  endtask

  task automatic test_random();
    bit to;
    int d0, bad;
    logic [AW-1:0] a;
    logic [LW-1:0] l, l2;
    logic [AW-1:0] ea;
    for (int it = 0; it < 30; it++) begin
      a  = (it % 4 == 0) ? AW'(MEM - 1 - $urandom_range(5)) : AW'($urandom);
      l  = LW'($urandom_range(15));
      l2 = LW'($urandom_range(int'(l)));
      // Write burst, with stray ai_valid asserted that must be ignored.
      clear_obs();
      wdat.delete();
      for (int i = 0; i <= int'(l); i++) wdat.push_back(DW'($urandom));
      d0       = done_cnt;
      ai_force = 1'b1;
      issue(1'b1, a, l, to);
      stream_write(30, to);
      tick();
      ai_force = 1'b0;
      for (int i = 0; i <= int'(l); i++) ref_mem[(int'(a) + i) % MEM] = wdat[i];
      tests++;
      if (to !== 1'b0 || wq_addr.size() != int'(l) + 1 || done_cnt - d0 != 1 || rd_valid) begin
        fails++;
        $display("FAIL rnd%0d_wr_count: timeout=%0b strobes=%0d dones=%0d rd_valid=%b want 0/%0d/1/0",
                 it, to, wq_addr.size(), done_cnt - d0, rd_valid, int'(l) + 1);
      end else begin
        bad = 0;
        for (int i = 0; i <= int'(l); i++) begin
          ea = AW'((int'(a) + i) % MEM);
          if (wq_addr[i] !== ea || wq_data[i] !== wdat[i]) bad++;
        end
        tests++;
        if (bad != 0) begin
          fails++;
          $display("FAIL rnd%0d_wr_seq: %0d strobes wrong want 0", it, bad);
        end
      end
      // Read back a prefix of the same range under random wait states and backpressure.
      clear_obs();
      d0        = done_cnt;
      sram_wait = $urandom_range(3, 1);
      issue(1'b0, a, l2, to);
      stream_read(40, to);
      tick();
      tests++;
      if (to !== 1'b0 || rq.size() != int'(l2) + 1 || done_cnt - d0 != 1) begin
        fails++;
        $display("FAIL rnd%0d_rd_count: timeout=%0b words=%0d dones=%0d want 0/%0d/1", it, to,
                 rq.size(), done_cnt - d0, int'(l2) + 1);
      end else begin
        bad = 0;
        for (int i = 0; i <= int'(l2); i++) begin
          if (rq[i] !== ref_mem[(int'(a) + i) % MEM]) bad++;
        end
        tests++;
        if (bad != 0) begin
          fails++;
          $display("FAIL rnd%0d_rd_seq: %0d words wrong want 0", it, bad);
        end
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got hang want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_basic();
    test_write_wrap();
    test_read_basic();
    test_read_backpressure();
    test_reset_mid_read();
    test_cmd_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
